// File: rtl/klein_pkg.sv
// Shared KLEIN-64 definitions: S-box, GF(2^8) doubling, 32-bit MixColumn, sizes, FSM states.
// Latency: n/a (pure functions and constants).
// Backpressure: n/a.
package klein_pkg;

    localparam int NROUNDS = 12;
    localparam int NBYTES  = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_ROUND = 2'd2,
        ST_OUT   = 2'd3
    } fsm_t;

    function automatic logic [3:0] sbox(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'h7;
            4'h1: y = 4'h4;
            4'h2: y = 4'hA;
            4'h3: y = 4'h9;
            4'h4: y = 4'h1;
            4'h5: y = 4'hF;
            4'h6: y = 4'hB;
            4'h7: y = 4'h0;
            4'h8: y = 4'hC;
            4'h9: y = 4'h3;
            4'hA: y = 4'h2;
            4'hB: y = 4'h6;
            4'hC: y = 4'h8;
            4'hD: y = 4'hE;
            4'hE: y = 4'hD;
            default: y = 4'h5;
        endcase
        return y;
    endfunction

    // Multiply by 2 in GF(2^8) modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
    endfunction

    // AES MixColumn; bits [31:24] are byte 0 of the column.
    function automatic logic [31:0] mix_column(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        logic [7:0] r0, r1, r2, r3;
        a0 = c[31:24];
        a1 = c[23:16];
        a2 = c[15:8];
        a3 = c[7:0];
        r0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
        r1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
        r2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
        r3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        return {r0, r1, r2, r3};
    endfunction

endpackage

// File: rtl/klein64_round.sv
// One KLEIN-64 round plus the matching key-schedule step, purely combinational.
// Latency: 0 cycles. Backpressure: none.
// Ports: state/sk (in, 64b, byte 0 in [63:56]), rnd (in, round index i), state_next/sk_next (out).
module klein64_round
    import klein_pkg::*;
(
    input  logic [63:0] state,
    input  logic [63:0] sk,
    input  logic [4:0]  rnd,
    output logic [63:0] state_next,
    output logic [63:0] sk_next
);

    logic [63:0] t;
    logic [63:0] s;
    logic [63:0] r;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] na;
    logic [31:0] nb;

    always_comb begin
        t = state ^ sk;
        s = '0;
        for (int n = 0; n < 16; n++) begin
            s[4*n +: 4] = sbox(t[4*n +: 4]);
        end
        // Rotate left by two bytes, then mix each 32-bit half.
        r = {s[47:0], s[63:48]};
        state_next = {mix_column(r[63:32]), mix_column(r[31:0])};

        // Key schedule: byte-rotate each half, Feistel swap, round constant, S-boxes.
        a  = {sk[55:32], sk[63:56]};
        b  = {sk[23:0],  sk[31:24]};
        na = b;
        nb = a ^ b;
        na[15:8]  = na[15:8] ^ {3'b000, rnd};
        nb[23:20] = sbox(nb[23:20]);
        nb[19:16] = sbox(nb[19:16]);
        nb[15:12] = sbox(nb[15:12]);
        nb[11:8]  = sbox(nb[11:8]);
        sk_next = {na, nb};
    end

endmodule

// File: rtl/klein_64.sv
// Alias wrapper exposing klein64 under the klein_64 instance name.
// Latency: identical to klein64. Backpressure: identical to klein64.
// Ports: same as klein64.
module klein_64 (
    input  logic       ck,
    input  logic       rst_n,
    input  logic       start,
    input  logic [0:7] inp,
    input  logic [0:7] key,
    output logic       ready,
    output logic [0:7] out
);

    klein64 u_core (
        .ck    (ck),
        .rst_n (rst_n),
        .start (start),
        .inp   (inp),
        .key   (key),
        .ready (ready),
        .out   (out)
    );

endmodule

// File: rtl/klein64.sv
// Byte-serial KLEIN-64 encryptor: loads 8 plaintext/key byte pairs, runs 12 rounds, streams 8 ciphertext bytes.
// Latency: first ciphertext byte 20 cycles after the start edge; one block per 29 cycles.
// Backpressure: none; start is ignored while a block is in flight, out is a fixed-rate stream qualified by ready.
// Ports: ck, rst_n (async active-low), start (pulse, byte 0), inp/key (byte in, bit 0 = MSB), ready, out (byte out).
module klein64
    import klein_pkg::*;
(
    input  logic       ck,
    input  logic       rst_n,
    input  logic       start,
    input  logic [0:7] inp,
    input  logic [0:7] key,
    output logic       ready,
    output logic [0:7] out
);

    fsm_t        fsm;
    fsm_t        fsm_nxt;
    logic [4:0]  cnt;
    logic [63:0] state_r;
    logic [63:0] sk_r;
    logic [63:0] out_sr;
    logic        ready_r;
    logic [63:0] state_nxt;
    logic [63:0] sk_nxt;

    // In ROUND, cnt holds the current round index 1..12.
    klein64_round u_round (
        .state      (state_r),
        .sk         (sk_r),
        .rnd        (cnt),
        .state_next (state_nxt),
        .sk_next    (sk_nxt)
    );

    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            fsm <= ST_IDLE;
        end else begin
            fsm <= fsm_nxt;
        end
    end

    always_comb begin
        fsm_nxt = fsm;
        case (fsm)
            ST_IDLE:  if (start)                    fsm_nxt = ST_LOAD;
            ST_LOAD:  if (cnt == 5'(NBYTES - 1))    fsm_nxt = ST_ROUND;
            ST_ROUND: if (cnt == 5'(NROUNDS))       fsm_nxt = ST_OUT;
            ST_OUT:   if (cnt == 5'(NBYTES))        fsm_nxt = ST_IDLE;
            default:                                fsm_nxt = ST_IDLE;
        endcase
    end

    // OUT spends cnt=0 loading the ciphertext, cnt=1..7 shifting, cnt=8 clearing.
    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            state_r <= '0;
            sk_r    <= '0;
            out_sr  <= '0;
            ready_r <= 1'b0;
        end else begin
            case (fsm)
                ST_IDLE: begin
                    if (start) begin
                        state_r <= {state_r[55:0], inp};
                        sk_r    <= {sk_r[55:0], key};
                        cnt     <= 5'd1;
                    end
                end
                ST_LOAD: begin
                    state_r <= {state_r[55:0], inp};
                    sk_r    <= {sk_r[55:0], key};
                    cnt     <= (cnt == 5'(NBYTES - 1)) ? 5'd1 : cnt + 5'd1;
                end
                ST_ROUND: begin
                    state_r <= state_nxt;
                    sk_r    <= sk_nxt;
                    cnt     <= (cnt == 5'(NROUNDS)) ? 5'd0 : cnt + 5'd1;
                end
                ST_OUT: begin
                    if (cnt == 5'd0) begin
                        out_sr  <= state_r ^ sk_r;
                        ready_r <= 1'b1;
                        cnt     <= cnt + 5'd1;
                    end else if (cnt == 5'(NBYTES)) begin
                        out_sr  <= '0;
                        ready_r <= 1'b0;
                        cnt     <= 5'd0;
                    end else begin
                        out_sr  <= {out_sr[55:0], 8'h00};
                        cnt     <= cnt + 5'd1;
                    end
                end
                default: begin
                    cnt <= 5'd0;
                end
            endcase
        end
    end

    assign ready = ready_r;
    assign out   = ready_r ? out_sr[63:56] : 8'h00;

endmodule

// File: tb/tb_klein64.sv
module tb_klein64;

    logic       ck = 1'b0;
    logic       rst_n;
    logic       start;
    logic [0:7] inp;
    logic [0:7] key_in;
    logic       ready;
    logic [0:7] out_b;

    int compared   = 0;
    int mismatched = 0;

    klein64 dut (
        .ck    (ck),
        .rst_n (rst_n),
        .start (start),
        .inp   (inp),
        .key   (key_in),
        .ready (ready),
        .out   (out_b)
    );

    always #5 ck = ~ck;

    typedef struct {
        logic [63:0] pt;
        logic [63:0] key;
        logic [63:0] ct;
        bit          extra;
    } vec_t;

    vec_t vecs[5];

    // ---------------- reference model (byte arrays, generic GF multiply) ----------------
    function automatic logic [7:0] sbyte(input logic [7:0] x);
        int t[16] = '{7, 4, 10, 9, 1, 15, 11, 0, 12, 3, 2, 6, 8, 14, 13, 5};
        return 8'(t[x[7:4]] * 16 + t[x[3:0]]);
    endfunction

    function automatic logic [7:0] gmul(input int c, input logic [7:0] v);
        int p = 0;
        int a = int'(v);
        for (int i = 0; i < 8; i++) begin
            if (((c >> i) & 1) == 1) p = p ^ a;
            a = a << 1;
            if ((a & 256) != 0) a = a ^ 'h11B;
        end
        return 8'(p);
    endfunction

    function automatic logic [63:0] klein_ref(input logic [63:0] pt, input logic [63:0] k);
        int m[16] = '{2, 3, 1, 1, 1, 2, 3, 1, 1, 1, 2, 3, 3, 1, 1, 2};
        logic [7:0] st[8];
        logic [7:0] sk[8];
        logic [7:0] tmp[8];
        logic [7:0] a[4];
        logic [7:0] b[4];
        logic [7:0] acc;
        logic [63:0] res;
        for (int i = 0; i < 8; i++) begin
            st[i] = pt[56 - 8*i +: 8];
            sk[i] = k[56 - 8*i +: 8];
        end
        for (int r = 1; r <= 12; r++) begin
            for (int i = 0; i < 8; i++) st[i] = sbyte(st[i] ^ sk[i]);
            for (int i = 0; i < 8; i++) tmp[i] = st[(i + 2) % 8];
            for (int h = 0; h < 2; h++) begin
                for (int row = 0; row < 4; row++) begin
                    acc = 8'h00;
                    for (int col = 0; col < 4; col++) acc = acc ^ gmul(m[row*4 + col], tmp[4*h + col]);
                    st[4*h + row] = acc;
                end
            end
            for (int j = 0; j < 4; j++) begin
                a[j] = sk[(j + 1) % 4];
                b[j] = sk[4 + (j + 1) % 4];
            end
            for (int j = 0; j < 4; j++) begin
                sk[j]     = b[j];
                sk[4 + j] = a[j] ^ b[j];
            end
            sk[2] = sk[2] ^ 8'(r);
            sk[5] = sbyte(sk[5]);
            sk[6] = sbyte(sk[6]);
        end
        res = '0;
        for (int i = 0; i < 8; i++) res[56 - 8*i +: 8] = st[i] ^ sk[i];
        return res;
    endfunction

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Entered at a falling edge; the edge labels E0..E28 are relative to the start pulse.
    task automatic drive_edge(input int e, input logic [63:0] pt, input logic [63:0] k, input bit extra);
        start = (e == 0) || (extra && (e == 5 || e == 22));
        if (e < 8) begin
            inp    = pt[8*(7 - e) +: 8];
            key_in = k[8*(7 - e) +: 8];
        end else begin
            inp    = 8'($urandom);
            key_in = 8'($urandom);
        end
        @(posedge ck);
        @(negedge ck);
    endtask

    task automatic run_block(input logic [63:0] pt, input logic [63:0] k, input logic [63:0] ct,
                             input bit extra, input string tag);
        for (int e = 0; e <= 28; e++) begin
            drive_edge(e, pt, k, extra);
            if (e >= 20 && e < 28) begin
                check($sformatf("%s ready E%0d", tag, e), {63'd0, ready}, 64'd1);
                check($sformatf("%s out E%0d", tag, e), {56'd0, out_b}, {56'd0, ct[8*(27 - e) +: 8]});
            end else begin
                check($sformatf("%s ready E%0d", tag, e), {63'd0, ready}, 64'd0);
                check($sformatf("%s out E%0d", tag, e), {56'd0, out_b}, 64'd0);
            end
        end
        start = 1'b0;
    endtask

    task automatic run_partial(input logic [63:0] pt, input logic [63:0] k, input int n);
        for (int e = 0; e < n; e++) drive_edge(e, pt, k, 1'b0);
        start = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] pt;
        logic [63:0] k;

        rst_n  = 1'b0;
        start  = 1'b0;
        inp    = 8'h00;
        key_in = 8'h00;
        repeat (2) @(negedge ck);
        check("reset ready", {63'd0, ready}, 64'd0);
        check("reset out", {56'd0, out_b}, 64'd0);
        rst_n = 1'b1;
        @(negedge ck);

        vecs[0] = '{64'h0000000000000000, 64'hFFFFFFFFFFFFFFFF, 64'h6456764E8602E154, 1'b0};
        vecs[1] = '{64'hFFFFFFFFFFFFFFFF, 64'h0000000000000000, 64'hCDC0B51F14722BBE, 1'b0};
        vecs[2] = '{64'hFFFFFFFFFFFFFFFF, 64'h1234567890ABCDEF, 64'h592356C4997176C8, 1'b0};
        vecs[3] = '{64'h1234567890ABCDEF, 64'h0000000000000000, 64'h629F9D6DFF95800E, 1'b0};
        vecs[4] = '{64'hFFFFFFFFFFFFFFFF, 64'h1234567890ABCDEF, 64'h592356C4997176C8, 1'b1};

        // Known-answer vectors, issued back to back (each start lands on the first IDLE edge).
        for (int v = 0; v < 5; v++) begin
            run_block(vecs[v].pt, vecs[v].key, vecs[v].ct, vecs[v].extra, $sformatf("kat%0d", v));
        end

        // Random blocks against the reference model, some with stray start pulses.
        for (int r = 0; r < 6; r++) begin
            pt = {$urandom, $urandom};
            k  = {$urandom, $urandom};
            run_block(pt, k, klein_ref(pt, k), (r % 2) == 1, $sformatf("rnd%0d", r));
        end

        // Reset in the middle of the round phase, then a fresh block.
        run_partial(64'hA5A5A5A5A5A5A5A5, 64'h0123456789ABCDEF, 13);
        rst_n = 1'b0;
        #1;
        check("rst_round ready", {63'd0, ready}, 64'd0);
        check("rst_round out", {56'd0, out_b}, 64'd0);
        @(negedge ck);
        check("rst_round hold ready", {63'd0, ready}, 64'd0);
        check("rst_round hold out", {56'd0, out_b}, 64'd0);
        rst_n = 1'b1;
        run_block(vecs[3].pt, vecs[3].key, vecs[3].ct, 1'b0, "after_rst_round");

        // Reset while ciphertext is streaming: outputs must clear without waiting for a clock.
        run_partial(vecs[1].pt, vecs[1].key, 24);
        check("pre_rst_out ready", {63'd0, ready}, 64'd1);
        rst_n = 1'b0;
        #1;
        check("rst_out ready", {63'd0, ready}, 64'd0);
        check("rst_out out", {56'd0, out_b}, 64'd0);
        @(negedge ck);
        rst_n = 1'b1;
        pt = {$urandom, $urandom};
        k  = {$urandom, $urandom};
        run_block(pt, k, klein_ref(pt, k), 1'b0, "after_rst_out");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
